// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger river logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   river_state_t : frog river state (LAND, RIDING, SINKING, DROWNED)
//   SCREEN_W      : visible screen width in pixels
//   FROG_W        : frog sprite width in pixels
//   row_idx_w()   : bit width needed to index a given number of rows (min 1)
package frogger_pkg;

    typedef enum logic [1:0] {
        LAND    = 2'd0,
        RIDING  = 2'd1,
        SINKING = 2'd2,
        DROWNED = 2'd3
    } river_state_t;

    localparam int SCREEN_W = 640;
    localparam int FROG_W   = 32;

    function automatic int row_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/river_row_select.sv
// Finds which river row (if any) contains the frog's top edge, lowest index wins.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   frog_y    : frog top-left Y
//   row_y     : top Y of each river row
//   row_valid : frog Y lies inside at least one row
//   row_idx   : lowest-numbered matching row (0 when row_valid is low)
module river_row_select
    import frogger_pkg::*;
#(
    parameter int NUM_ROWS   = 4,
    parameter int ROW_HEIGHT = 32
) (
    input  logic [10:0]                      frog_y,
    input  logic [NUM_ROWS-1:0][10:0]        row_y,
    output logic                             row_valid,
    output logic [row_idx_w(NUM_ROWS)-1:0]   row_idx
);

    localparam int IW = row_idx_w(NUM_ROWS);

    // Scan from the top index down so the lowest matching row is written last.
    // Compare in 12 bits so row_y + ROW_HEIGHT cannot wrap near the bottom of the range.
    always_comb begin
        row_valid = 1'b0;
        row_idx   = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (({1'b0, frog_y} >= {1'b0, row_y[r]}) &&
                ({1'b0, frog_y} <  ({1'b0, row_y[r]} + 12'(ROW_HEIGHT)))) begin
                row_valid = 1'b1;
                row_idx   = IW'(r);
            end
        end
    end

endmodule

// File: rtl/frog_river_tracker.sv
// Per-frame frog river state machine: riding, sinking, drowned; emits pad drift steps.
// Latency: all outputs registered, one frame_clk edge after the inputs they reflect.
// Backpressure: none; evaluates every frame and never stalls.
//
// Optional feature macro: RIVER_GRACE_EN
//   defined   : off-pad frames in a river row enter SINKING; drown after GRACE_FRAMES
//   undefined : no SINKING state; off-pad in a river row drowns on the next edge
//
// Ports:
//   frame_clk     : one rising edge per video frame
//   Reset         : synchronous, active-high
//   Frog_X/Frog_Y : frog top-left position
//   Row_Y         : top Y of each river row
//   Row_Direction : per-row pad direction (1 = right)
//   Row_Collision : frog overlaps an active pad in that row
//   Row_Remainder : per-row pad move remainder; 0 means the pad moves this frame
//   Drift_Step    : apply a 1-pixel drift this frame
//   Drift_Dir     : drift direction (1 = right)
//   Frog_Drown    : one-frame pulse on entry to DROWNED
//   Frog_Respawn  : one-frame pulse on DROWNED -> LAND
//   Frog_Dead     : high throughout DROWNED
module frog_river_tracker #(
    parameter int NUM_ROWS       = 4,
    parameter int ROW_HEIGHT     = 32,
    parameter int GRACE_FRAMES   = 4,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SCREEN_W       = frogger_pkg::SCREEN_W,
    parameter int FROG_W         = frogger_pkg::FROG_W
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic [10:0]                Frog_X,
    input  logic [10:0]                Frog_Y,
    input  logic [NUM_ROWS-1:0][10:0]  Row_Y,
    input  logic [NUM_ROWS-1:0]        Row_Direction,
    input  logic [NUM_ROWS-1:0]        Row_Collision,
    input  logic [NUM_ROWS-1:0][5:0]   Row_Remainder,
    output logic                       Drift_Step,
    output logic                       Drift_Dir,
    output logic                       Frog_Drown,
    output logic                       Frog_Respawn,
    output logic                       Frog_Dead
);

    // Explicit imports keep the package screen constants from colliding with
    // the same-named parameters above.
    import frogger_pkg::river_state_t;
    import frogger_pkg::row_idx_w;
    import frogger_pkg::LAND;
    import frogger_pkg::RIDING;
    import frogger_pkg::SINKING;
    import frogger_pkg::DROWNED;

    localparam int          IW           = row_idx_w(NUM_ROWS);
    localparam logic [10:0] X_MAX        = 11'(SCREEN_W - FROG_W);
    localparam logic [7:0]  RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
`ifdef RIVER_GRACE_EN
    localparam logic [7:0]  GRACE_LAST   = 8'(GRACE_FRAMES - 1);
`endif

    // Frame counters are 8 bits; parameters beyond that range cannot be honoured.
    if (GRACE_FRAMES < 1 || GRACE_FRAMES > 256) begin : g_grace_range
        $error("GRACE_FRAMES must be in 1..256");
    end
    if (RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 256) begin : g_respawn_range
        $error("RESPAWN_FRAMES must be in 1..256");
    end

    river_state_t    state_q, state_d;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;
    logic            row_valid;
    logic [IW-1:0]   row_idx;
    logic            sel_coll, sel_dir, sel_move, at_edge;
    logic            step_d, dir_d, drown_d, respawn_d;

    river_row_select #(
        .NUM_ROWS   (NUM_ROWS),
        .ROW_HEIGHT (ROW_HEIGHT)
    ) u_row_select (
        .frog_y    (Frog_Y),
        .row_y     (Row_Y),
        .row_valid (row_valid),
        .row_idx   (row_idx)
    );

    assign sel_coll = Row_Collision[row_idx];
    assign sel_dir  = Row_Direction[row_idx];
    assign sel_move = (Row_Remainder[row_idx] == 6'd0);
    // A drift that would push the frog off-screen carries it away instead.
    assign at_edge  = sel_dir ? (Frog_X >= X_MAX) : (Frog_X == 11'd0);
    // One counter serves both grace and respawn timing; it saturates, never wraps.
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        dir_d     = 1'b0;
        drown_d   = 1'b0;
        respawn_d = 1'b0;
        case (state_q)
            LAND: begin
                if (row_valid) begin
                    if (sel_coll) begin
                        state_d = RIDING;
                    end else begin
`ifdef RIVER_GRACE_EN
                        state_d = SINKING;
                        cnt_d   = '0;
`else
                        state_d = DROWNED;
                        cnt_d   = '0;
                        drown_d = 1'b1;
`endif
                    end
                end
            end
            RIDING: begin
                if (!row_valid) begin
                    state_d = LAND;
                end else if (!sel_coll) begin
`ifdef RIVER_GRACE_EN
                    state_d = SINKING;
                    cnt_d   = '0;
`else
                    state_d = DROWNED;
                    cnt_d   = '0;
                    drown_d = 1'b1;
`endif
                end else if (sel_move) begin
                    if (at_edge) begin
                        state_d = DROWNED;
                        cnt_d   = '0;
                        drown_d = 1'b1;
                    end else begin
                        step_d = 1'b1;
                        dir_d  = sel_dir;
                    end
                end
            end
`ifdef RIVER_GRACE_EN
            SINKING: begin
                if (!row_valid) begin
                    state_d = LAND;
                    cnt_d   = '0;
                end else if (sel_coll) begin
                    state_d = RIDING;
                    cnt_d   = '0;
                end else if (cnt_inc >= GRACE_LAST) begin
                    state_d = DROWNED;
                    cnt_d   = '0;
                    drown_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            DROWNED: begin
                if (cnt_q >= RESPAWN_LAST) begin
                    state_d   = LAND;
                    cnt_d     = '0;
                    respawn_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = LAND;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= LAND;
            cnt_q        <= '0;
            Drift_Step   <= 1'b0;
            Drift_Dir    <= 1'b0;
            Frog_Drown   <= 1'b0;
            Frog_Respawn <= 1'b0;
            Frog_Dead    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            Drift_Step   <= step_d;
            Drift_Dir    <= dir_d;
            Frog_Drown   <= drown_d;
            Frog_Respawn <= respawn_d;
            Frog_Dead    <= (state_d == DROWNED);
        end
    end

endmodule

// File: tb/tb_frog_river_tracker.sv
// Directed stimulus with a scoreboard: each frame's expected outputs are queued
// when its inputs are applied; a monitor pops and compares after every edge.
// Output vector order: {Drift_Step, Drift_Dir, Frog_Drown, Frog_Respawn, Frog_Dead}.
module tb_frog_river_tracker;

    logic             frame_clk = 1'b0;
    logic             Reset;
    logic [10:0]      Frog_X, Frog_Y;
    logic [3:0][10:0] Row_Y;
    logic [3:0]       Row_Direction, Row_Collision;
    logic [3:0][5:0]  Row_Remainder;
    logic             Drift_Step, Drift_Dir, Frog_Drown, Frog_Respawn, Frog_Dead;

    frog_river_tracker dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .Frog_X        (Frog_X),
        .Frog_Y        (Frog_Y),
        .Row_Y         (Row_Y),
        .Row_Direction (Row_Direction),
        .Row_Collision (Row_Collision),
        .Row_Remainder (Row_Remainder),
        .Drift_Step    (Drift_Step),
        .Drift_Dir     (Drift_Dir),
        .Frog_Drown    (Frog_Drown),
        .Frog_Respawn  (Frog_Respawn),
        .Frog_Dead     (Frog_Dead)
    );

    always #5 frame_clk = ~frame_clk;

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_DR_R  = 5'b11000;
    localparam logic [4:0] O_DR_L  = 5'b10000;
    localparam logic [4:0] O_DROWN = 5'b00101;
    localparam logic [4:0] O_RESP  = 5'b00010;
    localparam logic [4:0] O_DEAD  = 5'b00001;

    logic [4:0] exp_q[$];
    string      nm_q[$];
    int         checks = 0;
    int         errors = 0;

    // Values copied onto the DUT inputs at the next falling edge.
    logic [10:0]      tb_x;
    logic [3:0]       tb_dir;
    logic [3:0][10:0] tb_row_y;

    task automatic frame(input logic rst, input logic [10:0] y, input logic [3:0] coll,
                         input logic [5:0] rem, input logic [4:0] exp, input string nm);
        @(negedge frame_clk);
        Reset         = rst;
        Frog_X        = tb_x;
        Frog_Y        = y;
        Row_Y         = tb_row_y;
        Row_Direction = tb_dir;
        Row_Collision = coll;
        for (int r = 0; r < 4; r++) Row_Remainder[r] = rem;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
    endtask

    // 59 more DROWNED frames after the entry frame, then the respawn frame.
    task automatic dead_then_respawn(input string nm);
        for (int i = 0; i < 59; i++) frame(1'b0, 11'd210, 4'b0000, 6'd5, O_DEAD, {nm, "_dead"});
        frame(1'b0, 11'd210, 4'b0000, 6'd5, O_RESP, {nm, "_respawn"});
        frame(1'b0, 11'd50, 4'b0000, 6'd5, O_NONE, {nm, "_land"});
    endtask

    // Monitor: every edge produces one output frame.
    initial begin : monitor
        logic [4:0] got, e;
        string      n;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                n   = nm_q.pop_front();
                got = {Drift_Step, Drift_Dir, Frog_Drown, Frog_Respawn, Frog_Dead};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s got=%b expected=%b (step,dir,drown,respawn,dead)", n, got, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tb_x        = 11'd100;
        tb_dir      = 4'b0010;
        tb_row_y[0] = 11'd100;
        tb_row_y[1] = 11'd200;
        tb_row_y[2] = 11'd300;
        tb_row_y[3] = 11'd400;

        // Reset state
        frame(1'b1, 11'd50, 4'b0000, 6'd5, O_NONE, "reset0");
        frame(1'b1, 11'd50, 4'b0000, 6'd5, O_NONE, "reset1");
        frame(1'b0, 11'd50, 4'b0000, 6'd0, O_NONE, "land_idle");

        // Ride row 1 rightward, remainder 2,1,0: one drift step after remainder 0
        frame(1'b0, 11'd210, 4'b0010, 6'd2, O_NONE, "enter_ride");
        frame(1'b0, 11'd210, 4'b0010, 6'd1, O_NONE, "ride_rem1");
        frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DR_R, "drift_right");
        frame(1'b0, 11'd210, 4'b0010, 6'd2, O_NONE, "no_double_drift");

`ifdef RIVER_GRACE_EN
        // 3 off-pad frames then pad regained: survive
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_NONE, "sink1");
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_NONE, "sink2");
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_NONE, "sink3");
        frame(1'b0, 11'd210, 4'b0010, 6'd3, O_NONE, "regain");
        frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DR_R, "ride_after_regain");
        // 4 off-pad frames: drown on the 4th
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_NONE, "drop1");
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_NONE, "drop2");
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_NONE, "drop3");
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_DROWN, "drop4_drown");
`else
        // Without grace, a single off-pad frame drowns
        frame(1'b0, 11'd210, 4'b0000, 6'd3, O_DROWN, "drop_drown");
`endif
        dead_then_respawn("grace");

        // Left drift at Frog_X == 0: carried off, no drift step
        tb_dir = 4'b0000;
        tb_x   = 11'd0;
        frame(1'b0, 11'd210, 4'b0010, 6'd3, O_NONE, "left_enter");
        frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DROWN, "edge_left_drown");
        for (int i = 0; i < 29; i++) frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DEAD, "left_dead");
        // Reset in DROWNED frame 30: back to LAND, all zero, no respawn
        frame(1'b1, 11'd210, 4'b0010, 6'd0, O_NONE, "reset_mid_drowned");
        frame(1'b0, 11'd50, 4'b0000, 6'd0, O_NONE, "no_respawn");

        // Right edge: 608 is carried off, 607 drifts
        tb_dir = 4'b0010;
        tb_x   = 11'd608;
        frame(1'b0, 11'd210, 4'b0010, 6'd3, O_NONE, "right_enter");
        frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DROWN, "edge_right_drown");
        frame(1'b1, 11'd210, 4'b0010, 6'd0, O_NONE, "reset_after_right");
        tb_x   = 11'd607;
        frame(1'b0, 11'd210, 4'b0010, 6'd3, O_NONE, "r607_enter");
        frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DR_R, "r607_drift");
        tb_dir = 4'b0000;
        tb_x   = 11'd1;
        frame(1'b0, 11'd210, 4'b0010, 6'd0, O_DR_L, "drift_left_x1");
        frame(1'b0, 11'd50, 4'b0010, 6'd0, O_NONE, "back_to_land");

        // Row vertical bounds: 199 and 232 are land, 231 is row 1
        tb_dir = 4'b0010;
        tb_x   = 11'd100;
        frame(1'b0, 11'd199, 4'b0010, 6'd0, O_NONE, "y199_a");
        frame(1'b0, 11'd199, 4'b0010, 6'd0, O_NONE, "y199_b");
        frame(1'b0, 11'd232, 4'b0010, 6'd0, O_NONE, "y232_a");
        frame(1'b0, 11'd231, 4'b0010, 6'd0, O_NONE, "y231_enter");
        frame(1'b0, 11'd231, 4'b0010, 6'd0, O_DR_R, "y231_drift");
        frame(1'b0, 11'd232, 4'b0010, 6'd0, O_NONE, "y232_leave");

        // Rows 0 and 2 overlap; row 0 (no pad) must win over row 2 (pad)
        tb_row_y[2] = 11'd110;
`ifdef RIVER_GRACE_EN
        frame(1'b0, 11'd115, 4'b0100, 6'd0, O_NONE, "overlap_sink1");
        frame(1'b0, 11'd115, 4'b0100, 6'd0, O_NONE, "overlap_sink2");
        frame(1'b0, 11'd115, 4'b0100, 6'd0, O_NONE, "overlap_sink3");
        frame(1'b0, 11'd115, 4'b0100, 6'd0, O_DROWN, "overlap_drown");
`else
        frame(1'b0, 11'd115, 4'b0100, 6'd0, O_DROWN, "overlap_drown");
`endif
        frame(1'b1, 11'd50, 4'b0000, 6'd0, O_NONE, "final_reset");
        tb_row_y[2] = 11'd300;
        frame(1'b0, 11'd50, 4'b0000, 6'd0, O_NONE, "final_idle");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge frame_clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
